// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode constants, fetch state encoding and reset PC default
package riscv_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          ILEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_DRAIN = 3'd4
  } fetch_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - redirect target adder with JALR bit0 clear and misalign detect
module pc_target_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] offset,
  input  logic            jalr,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] sum;

  always_comb begin
    sum      = base + offset;
    target   = jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    misalign = (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// rtl/fetch_pc_sequencer.sv - PC owner and fetch FSM over a one-outstanding imem port
module fetch_pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              ILEN     = ILEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_valid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [ILEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redir_valid,
  input  logic            redir_jalr,
  input  logic [XLEN-1:0] redir_base,
  input  logic [XLEN-1:0] redir_offset,
  output logic            flush,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] if_inst_q, if_inst_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] tgt;
  logic            tgt_misalign;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .base     (redir_base),
    .offset   (redir_offset),
    .jalr     (redir_jalr),
    .target   (tgt),
    .misalign (tgt_misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    if (redir_valid) begin
      // A misaligned target still kills wrong-path work but leaves the PC alone.
      flush_d    = 1'b1;
      misalign_d = tgt_misalign;
      if (!tgt_misalign) pc_d = tgt;
      unique case (state_q)
        FETCH_REQ: begin
          state_d = imem_gnt ? FETCH_DRAIN : FETCH_IDLE;
          drop_d  = imem_gnt;
        end
        FETCH_WAIT: begin
          state_d = imem_valid ? FETCH_REQ : FETCH_DRAIN;
          drop_d  = !imem_valid;
        end
        FETCH_DRAIN: begin
          if (imem_valid) begin
            state_d = FETCH_REQ;
            drop_d  = 1'b0;
          end
        end
        default: state_d = FETCH_REQ;
      endcase
    end else begin
      unique case (state_q)
        FETCH_IDLE: state_d = FETCH_REQ;
        FETCH_REQ: begin
          if (imem_gnt) state_d = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_valid) begin
            if_inst_d = imem_rdata;
            if_pc_d   = pc_q;
            pc_d      = pc_q + XLEN'(4);
            state_d   = FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (id_ready) state_d = FETCH_REQ;
        end
        FETCH_DRAIN: begin
          if (imem_valid && drop_q) begin
            state_d = FETCH_REQ;
            drop_d  = 1'b0;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req     = (state_q == FETCH_REQ);
    imem_addr    = pc_q;
    if_valid     = (state_q == FETCH_HOLD);
    if_inst      = if_inst_q;
    if_pc        = if_pc_q;
    flush        = flush_q;
    misalign_err = misalign_q;
  end

endmodule
